// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side scheduler for a shared FIFO: burst grants with
// valid/ready per requester, occupancy credit counted at accept, push latency 1.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int COUNTWIDTH = 5,
  parameter int MAX_BURST  = 4,
  parameter int IDWIDTH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_pop,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data,
  output logic [COUNTWIDTH-1:0]    occupancy,
  output logic                     grant_valid,
  output logic [IDWIDTH-1:0]       grant_id,
  output logic                     underflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [0:0]         state;
  logic [IDWIDTH-1:0] last_grant;
  logic [BCW-1:0]     burst_cnt;
  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic               space, xfer, pop_ok, gvalid, glast, burst_end;
  logic               pick_found;
  logic [IDWIDTH-1:0] pick;
  int                 idx;

  // Credit is checked against registered occupancy only; a pop this cycle
  // makes room from the next cycle on.
  assign space  = occupancy < COUNTWIDTH'(DEPTH);
  assign gvalid = req_valid[grant_id];
  assign glast  = req_last[grant_id];
  assign xfer   = (state == BURST) && gvalid && space;
  assign pop_ok = fifo_pop && (occupancy != '0);
  assign burst_end = xfer && (glast || (burst_cnt == BCW'(MAX_BURST - 1)));
  assign grant_valid = (state == BURST);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign data_arr[i]  = req_data[i*WIDTH +: WIDTH];
    assign req_ready[i] = (state == BURST) && (grant_id == IDWIDTH'(i)) && space;
  end

  // First valid requester after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = IDWIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IDWIDTH'(NUM_REQ - 1);
      burst_cnt  <= '0;
      grant_id   <= '0;
      fifo_push  <= 1'b0;
      fifo_data  <= '0;
      occupancy  <= '0;
      underflow  <= 1'b0;
    end else begin
      fifo_push <= xfer;
      if (xfer) fifo_data <= data_arr[grant_id];

      case (state)
        IDLE: if (pick_found) begin
          state      <= BURST;
          grant_id   <= pick;
          last_grant <= pick;
          burst_cnt  <= '0;
        end
        BURST: begin
          // A full FIFO with valid held is a stall, not a release.
          if (!gvalid || burst_end) state <= IDLE;
          else if (xfer)            burst_cnt <= burst_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      case ({xfer, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase

      if (fifo_pop && (occupancy == '0)) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: pushed data checked against a
// scoreboard of accepted beats, plus grant order, credit and reset checks.
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           fifo_pop, fifo_push, grant_valid, underflow;
  logic [W-1:0]   fifo_data;
  logic [4:0]     occupancy;
  logic [1:0]     grant_id;

  logic [W-1:0] exp_q [$];
  int beat [N];
  int total = 0;
  int bad = 0;
  int push_cnt = 0;
  int base;

  fifo_write_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_pop(fifo_pop),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .occupancy(occupancy),
    .grant_valid(grant_valid), .grant_id(grant_id), .underflow(underflow)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] mk(input int i, input int b);
    return W'(16'hA000 + i * 256 + b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted beats before the edge, score pushes after it.
  task automatic cyc();
    logic [N-1:0] acc;
    logic [W-1:0] e;
    @(negedge clock);
    acc = req_valid & req_ready;
    if (reset)
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          exp_q.push_back(req_data[i*W +: W]);
          beat[i]++;
        end
    @(posedge clock);
    #1;
    if (fifo_push) begin
      push_cnt++;
      check("push_has_expect", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("push_data", 32'(fifo_data), 32'(e));
      end
    end
    for (int i = 0; i < N; i++) req_data[i*W +: W] = mk(i, beat[i]);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_last = '0; fifo_pop = 1'b0;
    for (int i = 0; i < N; i++) begin beat[i] = 0; req_data[i*W +: W] = mk(i, 0); end
    cyc(); cyc();
    check("rst_push", 32'(fifo_push), 32'(0));
    check("rst_data", 32'(fifo_data), 32'(0));
    check("rst_occ", 32'(occupancy), 32'(0));
    check("rst_gvalid", 32'(grant_valid), 32'(0));
    check("rst_gid", 32'(grant_id), 32'(0));
    check("rst_uflow", 32'(underflow), 32'(0));
    reset = 1'b1;

    // 1: all valid, round-robin 0..3 with full 4-beat bursts until full
    req_valid = 4'hF;
    for (int g = 0; g < N; g++) begin
      cyc();
      check("t1_gvalid", 32'(grant_valid), 32'(1));
      check("t1_gid", 32'(grant_id), 32'(g));
      for (int b = 0; b < 4; b++) begin
        check("t1_ready", 32'(req_ready), 32'(1 << g));
        cyc();
      end
      check("t1_idle", 32'(grant_valid), 32'(0));
    end
    check("t1_occ_full", 32'(occupancy), 32'(16));
    cyc();
    check("t1_wrap_gid", 32'(grant_id), 32'(0));
    for (int k = 0; k < 3; k++) begin
      check("t1_full_ready", 32'(req_ready), 32'(0));
      cyc();
    end
    check("t1_pushes", 32'(push_cnt), 32'(16));
    check("t1_occ_hold", 32'(occupancy), 32'(16));

    // 2: full, req 2 waiting; one pop lets exactly one beat in
    req_valid = 4'b0100;
    cyc();
    check("t2_release", 32'(grant_valid), 32'(0));
    cyc();
    check("t2_gid", 32'(grant_id), 32'(2));
    check("t2_stall", 32'(req_ready), 32'(0));
    fifo_pop = 1'b1;
    check("t2_pop_same_cycle", 32'(req_ready), 32'(0));
    cyc();
    fifo_pop = 1'b0;
    check("t2_occ15", 32'(occupancy), 32'(15));
    check("t2_ready_up", 32'(req_ready), 32'(4'b0100));
    base = push_cnt;
    cyc();
    check("t2_occ16", 32'(occupancy), 32'(16));
    check("t2_ready_down", 32'(req_ready), 32'(0));
    cyc();
    check("t2_one_push", 32'(push_cnt - base), 32'(1));
    req_valid = '0;
    cyc();
    fifo_pop = 1'b1;
    repeat (16) cyc();
    fifo_pop = 1'b0;
    check("t2_drained", 32'(occupancy), 32'(0));
    check("t2_no_uflow", 32'(underflow), 32'(0));

    // 3: req 1 alone, last on beat 2, then regrant after one idle cycle
    base = push_cnt;
    req_valid = 4'b0010;
    cyc();
    check("t3_gid", 32'(grant_id), 32'(1));
    cyc();
    req_last = 4'b0010;
    cyc();
    req_last = '0;
    check("t3_idle", 32'(grant_valid), 32'(0));
    cyc();
    check("t3_regrant", 32'(grant_valid), 32'(1));
    check("t3_regrant_id", 32'(grant_id), 32'(1));
    req_valid = '0;
    cyc();
    check("t3_pushes", 32'(push_cnt - base), 32'(2));
    check("t3_occ", 32'(occupancy), 32'(2));

    // 4: req 3 drops valid after one beat, grant wraps to 0
    req_valid = 4'b1001;
    cyc();
    check("t4_gid3", 32'(grant_id), 32'(3));
    cyc();
    req_valid = 4'b0001;
    cyc();
    check("t4_release", 32'(grant_valid), 32'(0));
    cyc();
    check("t4_gid0", 32'(grant_id), 32'(0));
    check("t4_gvalid", 32'(grant_valid), 32'(1));
    req_valid = '0;
    cyc();
    check("t4_occ", 32'(occupancy), 32'(3));

    // 5: underflow is sticky; reset mid-burst drops the in-flight beat
    fifo_pop = 1'b1;
    repeat (3) cyc();
    check("t5_empty", 32'(occupancy), 32'(0));
    cyc();
    fifo_pop = 1'b0;
    check("t5_occ_no_wrap", 32'(occupancy), 32'(0));
    check("t5_uflow", 32'(underflow), 32'(1));
    req_valid = 4'b0100;
    cyc();
    check("t5_uflow_sticky", 32'(underflow), 32'(1));
    check("t5_gid", 32'(grant_id), 32'(2));
    check("t5_ready", 32'(req_ready), 32'(4'b0100));
    base = push_cnt;
    reset = 1'b0;
    cyc();
    check("t5_rst_push", 32'(fifo_push), 32'(0));
    check("t5_rst_occ", 32'(occupancy), 32'(0));
    check("t5_rst_gvalid", 32'(grant_valid), 32'(0));
    check("t5_rst_gid", 32'(grant_id), 32'(0));
    check("t5_rst_uflow", 32'(underflow), 32'(0));
    check("t5_rst_data", 32'(fifo_data), 32'(0));
    req_valid = '0;
    reset = 1'b1;
    cyc();
    check("t5_no_late_push", 32'(push_cnt - base), 32'(0));
    check("sb_empty", 32'(exp_q.size()), 32'(0));
    check("total_pushes", 32'(push_cnt), 32'(20));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
